// File: rtl/mac_vec_engine.sv
// Pipelined multi-lane signed dot-product engine: products (S1), beat sum (S2),
// accumulate + requantise into a valid/ready output register.
module mac_vec_engine #(
    parameter int DATA_W  = 8,
    parameter int LANES   = 4,
    parameter int ACC_W   = 24,
    parameter int LEN_W   = 8,
    parameter int OUT_W   = 8,
    parameter int SHIFT_W = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clear,
    input  logic [LEN_W-1:0]          cfg_len,
    input  logic [SHIFT_W-1:0]        cfg_shift,
    input  logic                      cfg_sat,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LANES*DATA_W-1:0]   in_a,
    input  logic [LANES*DATA_W-1:0]   in_b,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [ACC_W-1:0]          out_acc,
    output logic [OUT_W-1:0]          out_q,
    output logic                      out_sat,
    output logic                      out_ovf
);
    localparam int PROD_W = 2 * DATA_W;
    localparam int CNT_W  = LEN_W + 1;
    localparam logic signed [ACC_W-1:0] Q_MAX = ACC_W'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] Q_MIN = ~Q_MAX;

    logic adv, accept, first, beat_last;
    logic [CNT_W-1:0]   cnt_q, len_q, len_eff, cur_len;
    logic [SHIFT_W-1:0] shift_q, cur_shift;
    logic               sat_q, cur_sat;

    logic [DATA_W-1:0]        lane_a, lane_b;
    logic [PROD_W-1:0]        a_ext, b_ext;
    logic [PROD_W-1:0]        prod_d [LANES];
    logic [PROD_W-1:0]        s1_prod_q [LANES];
    logic                     s1_valid_q, s1_last_q, s1_sat_q;
    logic [SHIFT_W-1:0]       s1_shift_q;

    logic [ACC_W-1:0]         ext, part, lane_sum;
    logic                     lane_ovf;
    logic [ACC_W-1:0]         s2_sum_q;
    logic                     s2_valid_q, s2_last_q, s2_sat_q, s2_ovf_q;
    logic [SHIFT_W-1:0]       s2_shift_q;

    logic signed [ACC_W-1:0]  acc_q, acc_sum, shifted;
    logic                     ovf_acc_q, add_ovf, tot_ovf;
    logic [OUT_W-1:0]         out_q_d;
    logic                     out_sat_d, load_out;

    logic                     out_valid_q, out_sat_q, out_ovf_q;
    logic [ACC_W-1:0]         out_acc_q;
    logic [OUT_W-1:0]         out_q_q;

    // Handshake: a beat moves when in_valid && in_ready; the whole pipe freezes
    // while a result sits unconsumed, and clear blocks acceptance for its cycle.
    assign adv      = !(out_valid_q && !out_ready);
    assign in_ready = adv && !clear && !rst;
    assign accept   = in_valid && in_ready;

    always_comb begin
        len_eff   = (cfg_len == '0) ? CNT_W'(1) : CNT_W'(cfg_len);
        first     = (cnt_q == '0);
        cur_len   = first ? len_eff : len_q;
        cur_shift = first ? cfg_shift : shift_q;
        cur_sat   = first ? cfg_sat : sat_q;
        beat_last = ((cnt_q + CNT_W'(1)) == cur_len);
    end

    always_comb begin
        lane_a = '0;
        lane_b = '0;
        a_ext  = '0;
        b_ext  = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_a    = in_a[i*DATA_W +: DATA_W];
            lane_b    = in_b[i*DATA_W +: DATA_W];
            a_ext     = {{DATA_W{lane_a[DATA_W-1]}}, lane_a};
            b_ext     = {{DATA_W{lane_b[DATA_W-1]}}, lane_b};
            prod_d[i] = a_ext * b_ext;
        end
    end

    always_comb begin
        lane_sum = '0;
        lane_ovf = 1'b0;
        ext      = '0;
        part     = '0;
        for (int i = 0; i < LANES; i++) begin
            ext  = {{(ACC_W-PROD_W){s1_prod_q[i][PROD_W-1]}}, s1_prod_q[i]};
            part = lane_sum + ext;
            if ((lane_sum[ACC_W-1] == ext[ACC_W-1]) && (part[ACC_W-1] != lane_sum[ACC_W-1]))
                lane_ovf = 1'b1;
            lane_sum = part;
        end
    end

    // The shift/saturate config travels with each beat so a short vector
    // following directly behind is requantised with its own settings.
    always_comb begin
        acc_sum   = acc_q + $signed(s2_sum_q);
        add_ovf   = (acc_q[ACC_W-1] == s2_sum_q[ACC_W-1]) && (acc_sum[ACC_W-1] != acc_q[ACC_W-1]);
        tot_ovf   = ovf_acc_q || s2_ovf_q || add_ovf;
        shifted   = acc_sum >>> s2_shift_q;
        out_sat_d = 1'b0;
        out_q_d   = shifted[OUT_W-1:0];
        if (s2_sat_q && (shifted > Q_MAX)) begin
            out_q_d   = Q_MAX[OUT_W-1:0];
            out_sat_d = 1'b1;
        end else if (s2_sat_q && (shifted < Q_MIN)) begin
            out_q_d   = Q_MIN[OUT_W-1:0];
            out_sat_d = 1'b1;
        end
        load_out = adv && !clear && s2_valid_q && s2_last_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            len_q      <= '0;
            shift_q    <= '0;
            sat_q      <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_shift_q <= '0;
            s1_sat_q   <= 1'b0;
            s1_prod_q  <= '{default: '0};
            s2_valid_q <= 1'b0;
            s2_last_q  <= 1'b0;
            s2_shift_q <= '0;
            s2_sat_q   <= 1'b0;
            s2_sum_q   <= '0;
            s2_ovf_q   <= 1'b0;
            acc_q      <= '0;
            ovf_acc_q  <= 1'b0;
        end else if (adv) begin
            if (clear) begin
                cnt_q      <= '0;
                s1_valid_q <= 1'b0;
                s2_valid_q <= 1'b0;
                acc_q      <= '0;
                ovf_acc_q  <= 1'b0;
            end else begin
                if (accept) begin
                    cnt_q <= beat_last ? '0 : cnt_q + CNT_W'(1);
                    if (first) begin
                        len_q   <= len_eff;
                        shift_q <= cfg_shift;
                        sat_q   <= cfg_sat;
                    end
                end
                s1_valid_q <= accept;
                s1_last_q  <= beat_last;
                s1_shift_q <= cur_shift;
                s1_sat_q   <= cur_sat;
                s1_prod_q  <= prod_d;
                s2_valid_q <= s1_valid_q;
                s2_last_q  <= s1_last_q;
                s2_shift_q <= s1_shift_q;
                s2_sat_q   <= s1_sat_q;
                s2_sum_q   <= lane_sum;
                s2_ovf_q   <= lane_ovf;
                if (s2_valid_q) begin
                    acc_q     <= s2_last_q ? '0 : acc_sum;
                    ovf_acc_q <= s2_last_q ? 1'b0 : tot_ovf;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_acc_q   <= '0;
            out_q_q     <= '0;
            out_sat_q   <= 1'b0;
            out_ovf_q   <= 1'b0;
        end else if (load_out) begin
            out_valid_q <= 1'b1;
            out_acc_q   <= acc_sum;
            out_q_q     <= out_q_d;
            out_sat_q   <= out_sat_d;
            out_ovf_q   <= tot_ovf;
        end else if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign out_acc   = out_acc_q;
    assign out_q     = out_q_q;
    assign out_sat   = out_sat_q;
    assign out_ovf   = out_ovf_q;
endmodule
